// File: rtl/ghost_mode_if.sv
// Ghost controller bundle: game events from the top level and the shared
// control lines fanned out to every ghost mover.
interface ghost_mode_if #(
    parameter int NUM_GHOSTS = 4
);
    logic                  i_start;
    logic                  i_power_pellet;
    logic [NUM_GHOSTS-1:0] i_collide;
    logic [1:0]            o_mode;
    logic [2:0]            o_phase;
    logic [NUM_GHOSTS-1:0] o_release;
    logic                  o_stop;
    logic                  o_reverse;
    logic [NUM_GHOSTS-1:0] o_ghost_eaten;
    logic                  o_pac_dead;
    logic                  o_fright_flash;

    modport master (
        output i_start, i_power_pellet, i_collide,
        input  o_mode, o_phase, o_release, o_stop, o_reverse,
               o_ghost_eaten, o_pac_dead, o_fright_flash
    );

    modport slave (
        input  i_start, i_power_pellet, i_collide,
        output o_mode, o_phase, o_release, o_stop, o_reverse,
               o_ghost_eaten, o_pac_dead, o_fright_flash
    );
endinterface

// File: rtl/ghost_mode_ctrl.sv
// Ghost game sequencer: scatter/chase phases, staggered release, frightened mode
// and collision resolution. Macro GHOST_FRIGHT_FLASH_EN enables the fright-ending flash.
module ghost_mode_ctrl #(
    parameter int NUM_GHOSTS     = 4,
    parameter int SCATTER_FRAMES = 420,
    parameter int CHASE_FRAMES   = 1200,
    parameter int NUM_PHASES     = 4,
    parameter int FRIGHT_FRAMES  = 360,
    parameter int RELEASE_GAP    = 120,
    parameter int FLASH_FRAMES   = 120
) (
    input  logic        frame_clk,
    input  logic        Reset,
    ghost_mode_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FRIGHT, ST_DEAD} state_t;

    localparam logic [11:0] SCATTER_LAST = 12'(SCATTER_FRAMES - 1);
    localparam logic [11:0] CHASE_LAST   = 12'(CHASE_FRAMES - 1);
    localparam logic [11:0] FRIGHT_LAST  = 12'(FRIGHT_FRAMES - 1);
    localparam logic [11:0] FLASH_START  = 12'(FRIGHT_FRAMES - FLASH_FRAMES);
    localparam logic [2:0]  LAST_PHASE   = 3'(2 * NUM_PHASES - 1);

`ifdef GHOST_FRIGHT_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    state_t                r_state, w_state_next;
    logic [2:0]            r_phase, w_phase_next;
    logic [11:0]           r_phase_tmr, w_phase_tmr_next;
    logic [11:0]           r_fright_tmr, w_fright_tmr_next;
    logic [11:0]           r_rel_tmr, w_rel_tmr_next;
    logic [NUM_GHOSTS-1:0] r_release, w_release_next;
    logic [NUM_GHOSTS-1:0] r_eaten_mask, w_eaten_mask_next;
    logic [NUM_GHOSTS-1:0] r_ghost_eaten, w_ghost_eaten_next;
    logic                  r_reverse, w_reverse_next;
    logic                  w_rel_adv;
    logic                  w_rel_load;
    logic [NUM_GHOSTS-1:0] w_hits;
    logic [NUM_GHOSTS-1:0] w_fresh;
    logic                  w_repeat_hit;

    // Ghosts still in the house cannot touch pac-man.
    assign w_hits       = bus.i_collide & r_release;
    assign w_fresh      = w_hits & ~r_eaten_mask;
    assign w_repeat_hit = |(w_hits & r_eaten_mask);

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        w_state_next       = r_state;
        w_phase_next       = r_phase;
        w_phase_tmr_next   = r_phase_tmr;
        w_fright_tmr_next  = r_fright_tmr;
        w_rel_tmr_next     = r_rel_tmr;
        w_release_next     = r_release;
        w_eaten_mask_next  = r_eaten_mask;
        w_ghost_eaten_next = '0;
        w_reverse_next     = 1'b0;
        w_rel_adv          = 1'b0;
        w_rel_load         = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_next      = ST_RUN;
                    w_phase_next      = '0;
                    w_phase_tmr_next  = '0;
                    w_fright_tmr_next = '0;
                    w_rel_tmr_next    = '0;
                    w_eaten_mask_next = '0;
                    w_rel_load        = 1'b1;
                end
            end
            ST_RUN: begin
                w_rel_adv = 1'b1;
                // The pellet outranks a same-cycle collision; it is rescored as frightened.
                if (bus.i_power_pellet) begin
                    w_state_next      = ST_FRIGHT;
                    w_reverse_next    = 1'b1;
                    w_fright_tmr_next = '0;
                    w_eaten_mask_next = '0;
                end else if (|w_hits) begin
                    w_state_next = ST_DEAD;
                end else if (r_phase != LAST_PHASE) begin
                    if (r_phase_tmr == (r_phase[0] ? CHASE_LAST : SCATTER_LAST)) begin
                        w_phase_next     = r_phase + 3'd1;
                        w_phase_tmr_next = '0;
                        w_reverse_next   = 1'b1;
                    end else begin
                        w_phase_tmr_next = r_phase_tmr + 12'd1;
                    end
                end
            end
            ST_FRIGHT: begin
                w_rel_adv          = 1'b1;
                w_ghost_eaten_next = w_fresh;
                w_eaten_mask_next  = r_eaten_mask | w_fresh;
                if (w_repeat_hit) begin
                    w_state_next = ST_DEAD;
                end else if (bus.i_power_pellet) begin
                    w_fright_tmr_next = '0;
                end else if (r_fright_tmr == FRIGHT_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_fright_tmr_next = r_fright_tmr + 12'd1;
                end
            end
            ST_DEAD: begin
            end
        endcase

        // Release timer saturates once the whole house is empty.
        if (w_rel_adv && !(&r_release)) begin
            w_rel_tmr_next = r_rel_tmr + 12'd1;
        end
        if (w_rel_adv || w_rel_load) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                if (w_rel_tmr_next == 12'(i * RELEASE_GAP)) begin
                    w_release_next[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_phase_tmr   <= '0;
            r_fright_tmr  <= '0;
            r_rel_tmr     <= '0;
            r_release     <= '0;
            r_eaten_mask  <= '0;
            r_ghost_eaten <= '0;
            r_reverse     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_phase       <= w_phase_next;
            r_phase_tmr   <= w_phase_tmr_next;
            r_fright_tmr  <= w_fright_tmr_next;
            r_rel_tmr     <= w_rel_tmr_next;
            r_release     <= w_release_next;
            r_eaten_mask  <= w_eaten_mask_next;
            r_ghost_eaten <= w_ghost_eaten_next;
            r_reverse     <= w_reverse_next;
        end
    end

    assign bus.o_mode         = (r_state == ST_FRIGHT) ? 2'b10 :
                                ((r_state == ST_RUN) && r_phase[0]) ? 2'b01 : 2'b00;
    assign bus.o_phase        = r_phase;
    assign bus.o_release      = r_release;
    assign bus.o_stop         = (r_state == ST_IDLE) || (r_state == ST_DEAD);
    assign bus.o_reverse      = r_reverse;
    assign bus.o_ghost_eaten  = r_ghost_eaten;
    assign bus.o_pac_dead     = (r_state == ST_DEAD);
    assign bus.o_fright_flash = FLASH_ON && (r_state == ST_FRIGHT) &&
                                (r_fright_tmr >= FLASH_START) && r_fright_tmr[3];
endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Bench for ghost_mode_ctrl: game-level model compared every frame, plus
// directed scenarios with hand-computed literal expectations.
module tb_ghost_mode_ctrl;
    localparam int NG      = 4;
    localparam int SC      = 4;
    localparam int CH      = 6;
    localparam int NP      = 1;
    localparam int FR      = 5;
    localparam int GAP     = 3;
    localparam int FL      = 2;
    localparam int LAST_PH = 2 * NP - 1;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   n_checks  = 0;
    int   n_errors  = 0;

    ghost_mode_if #(.NUM_GHOSTS(NG)) bus ();

    ghost_mode_ctrl #(
        .NUM_GHOSTS(NG), .SCATTER_FRAMES(SC), .CHASE_FRAMES(CH), .NUM_PHASES(NP),
        .FRIGHT_FRAMES(FR), .RELEASE_GAP(GAP), .FLASH_FRAMES(FL)
    ) dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 frame_clk = ~frame_clk;

    // Game-level model: frames of phase credit, frames alive, frightened frames left.
    typedef enum int {M_IDLE, M_RUN, M_FRIGHT, M_DEAD} m_state_t;
    m_state_t      m_state;
    int            m_credit;
    int            m_alive;
    int            m_fright_left;
    logic [NG-1:0] m_eaten;
    logic [NG-1:0] m_eat_pulse;
    logic          m_rev_pulse;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int dur(input int p);
        return (p % 2 == 1) ? CH : SC;
    endfunction

    function automatic int phase_of(input int credit);
        int p   = 0;
        int rem = credit;
        while (p < LAST_PH && rem >= dur(p)) begin
            rem -= dur(p);
            p++;
        end
        return p;
    endfunction

    function automatic logic [NG-1:0] rel_of();
        logic [NG-1:0] r = '0;
        if (m_state != M_IDLE)
            for (int i = 0; i < NG; i++) r[i] = (m_alive >= i * GAP);
        return r;
    endfunction

    task automatic model_reset();
        m_state       = M_IDLE;
        m_credit      = 0;
        m_alive       = 0;
        m_fright_left = 0;
        m_eaten       = '0;
        m_eat_pulse   = '0;
        m_rev_pulse   = 1'b0;
    endtask

    task automatic model_step();
        logic [NG-1:0] hits;
        logic [NG-1:0] fresh;
        int            old_ph;
        hits        = bus.i_collide & rel_of();
        fresh       = hits & ~m_eaten;
        m_rev_pulse = 1'b0;
        m_eat_pulse = '0;
        case (m_state)
            M_IDLE: if (bus.i_start) begin
                m_state  = M_RUN;
                m_credit = 0;
                m_alive  = 0;
                m_eaten  = '0;
            end
            M_RUN: begin
                m_alive++;
                if (bus.i_power_pellet) begin
                    m_state       = M_FRIGHT;
                    m_rev_pulse   = 1'b1;
                    m_fright_left = FR;
                    m_eaten       = '0;
                end else if (|hits) begin
                    m_state = M_DEAD;
                end else begin
                    old_ph = phase_of(m_credit);
                    m_credit++;
                    m_rev_pulse = (phase_of(m_credit) != old_ph);
                end
            end
            M_FRIGHT: begin
                m_alive++;
                m_eat_pulse = fresh;
                if (|(hits & m_eaten)) m_state = M_DEAD;
                else if (bus.i_power_pellet) m_fright_left = FR;
                else begin
                    m_fright_left--;
                    if (m_fright_left == 0) m_state = M_RUN;
                end
                m_eaten |= fresh;
            end
            default: ;
        endcase
    endtask

    task automatic compare_outputs();
        logic [1:0] exp_mode;
        logic       exp_flash;
        int         ft;
        exp_flash = 1'b0;
`ifdef GHOST_FRIGHT_FLASH_EN
        if (m_state == M_FRIGHT) begin
            ft        = FR - m_fright_left;
            exp_flash = (ft >= FR - FL) && ft[3];
        end
`else
        ft = 0;
`endif
        check("stop", bus.o_stop, (m_state == M_IDLE) || (m_state == M_DEAD));
        check("pac_dead", bus.o_pac_dead, m_state == M_DEAD);
        check("phase", bus.o_phase, phase_of(m_credit));
        check("release", bus.o_release, rel_of());
        check("reverse", bus.o_reverse, m_rev_pulse);
        check("ghost_eaten", bus.o_ghost_eaten, m_eat_pulse);
        check("fright_flash", bus.o_fright_flash, exp_flash);
        if (m_state == M_RUN || m_state == M_FRIGHT) begin
            exp_mode = (m_state == M_FRIGHT) ? 2'b10 : 2'(phase_of(m_credit) % 2);
            check("mode", bus.o_mode, exp_mode);
        end
    endtask

    initial forever begin
        @(posedge frame_clk);
        if (Reset === 1'b0) model_step();
    end

    initial forever begin
        @(negedge frame_clk);
        if (Reset === 1'b0) compare_outputs();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge frame_clk);
            #2;
        end
    endtask

    task automatic apply_reset();
        Reset              = 1'b1;
        model_reset();
        bus.i_start        = 1'b0;
        bus.i_power_pellet = 1'b0;
        bus.i_collide      = '0;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic start_game();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stop"}, bus.o_stop, 1'b1);
        check({tag, "_mode"}, bus.o_mode, 2'b00);
        check({tag, "_phase"}, bus.o_phase, 3'd0);
        check({tag, "_release"}, bus.o_release, 4'b0000);
        check({tag, "_reverse"}, bus.o_reverse, 1'b0);
        check({tag, "_eaten"}, bus.o_ghost_eaten, 4'b0000);
        check({tag, "_dead"}, bus.o_pac_dead, 1'b0);
        check({tag, "_flash"}, bus.o_fright_flash, 1'b0);
    endtask

    initial begin
        model_reset();
        bus.i_start        = 1'b0;
        bus.i_power_pellet = 1'b0;
        bus.i_collide      = '0;
        #3;
        check_reset_values("rst");
        tick(2);
        Reset = 1'b0;
        tick(2);
        check("idle_stop", bus.o_stop, 1'b1);

        // Game 1: release stagger and phase sequencing.
        start_game();
        check("g1_stop", bus.o_stop, 1'b0);
        check("g1_rel0", bus.o_release, 4'b0001);
        check("g1_mode0", bus.o_mode, 2'b00);
        tick(3);
        check("g1_rel3", bus.o_release, 4'b0011);
        check("g1_phase3", bus.o_phase, 3'd0);
        tick();
        check("g1_phase4", bus.o_phase, 3'd1);
        check("g1_mode4", bus.o_mode, 2'b01);
        check("g1_rev4", bus.o_reverse, 1'b1);
        tick();
        check("g1_rev5", bus.o_reverse, 1'b0);
        tick(4);
        check("g1_rel9", bus.o_release, 4'b1111);
        tick(12);
        check("g1_phase_hold", bus.o_phase, 3'd1);
        check("g1_mode_hold", bus.o_mode, 2'b01);

        // Game 2: unreleased ghost, pellet + collision, frightened pause of phase timer.
        apply_reset();
        start_game();
        bus.i_collide = 4'b1000;
        tick();
        check("g2_unrel_dead", bus.o_pac_dead, 1'b0);
        check("g2_unrel_stop", bus.o_stop, 1'b0);
        bus.i_collide = '0;
        tick();
        bus.i_power_pellet = 1'b1;
        bus.i_collide      = 4'b0001;
        tick();
        check("g2_fright_mode", bus.o_mode, 2'b10);
        check("g2_fright_rev", bus.o_reverse, 1'b1);
        check("g2_simul_dead", bus.o_pac_dead, 1'b0);
        bus.i_power_pellet = 1'b0;
        tick();
        check("g2_eat0", bus.o_ghost_eaten, 4'b0001);
        check("g2_eat0_dead", bus.o_pac_dead, 1'b0);
        bus.i_collide = '0;
        tick(3);
        check("g2_still_fright", bus.o_mode, 2'b10);
        tick();
        check("g2_back_mode", bus.o_mode, 2'b00);
        check("g2_back_rev", bus.o_reverse, 1'b0);
        tick();
        check("g2_phase_e9", bus.o_phase, 3'd0);
        tick();
        check("g2_phase_e10", bus.o_phase, 3'd1);
        check("g2_rev_e10", bus.o_reverse, 1'b1);

        // Game 3: eat, re-pellet, then collide with the eaten ghost.
        apply_reset();
        start_game();
        tick(2);
        bus.i_power_pellet = 1'b1;
        tick();
        bus.i_power_pellet = 1'b0;
        bus.i_collide      = 4'b0010;
        tick();
        check("g3_eat1", bus.o_ghost_eaten, 4'b0010);
        bus.i_collide = '0;
        tick();
        check("g3_eat_pulse_end", bus.o_ghost_eaten, 4'b0000);
        bus.i_power_pellet = 1'b1;
        tick();
        check("g3_repellet_rev", bus.o_reverse, 1'b0);
        check("g3_repellet_mode", bus.o_mode, 2'b10);
        bus.i_power_pellet = 1'b0;
        bus.i_collide      = 4'b0010;
        tick();
        check("g3_dead", bus.o_pac_dead, 1'b1);
        check("g3_dead_stop", bus.o_stop, 1'b1);
        bus.i_collide = '0;
        bus.i_start   = 1'b1;
        tick(3);
        check("g3_dead_hold", bus.o_pac_dead, 1'b1);
        check("g3_dead_stop_hold", bus.o_stop, 1'b1);
        bus.i_start = 1'b0;

        // Game 4: released-ghost collision while running.
        apply_reset();
        start_game();
        bus.i_collide = 4'b0001;
        tick();
        check("g4_run_dead", bus.o_pac_dead, 1'b1);
        check("g4_run_stop", bus.o_stop, 1'b1);
        bus.i_collide = '0;

        // Game 5: asynchronous reset while frightened.
        apply_reset();
        start_game();
        bus.i_power_pellet = 1'b1;
        tick();
        check("g5_fright", bus.o_mode, 2'b10);
        bus.i_power_pellet = 1'b0;
        tick();
        #1;
        Reset = 1'b1;
        model_reset();
        #1;
        check_reset_values("async");
        tick(2);
        Reset = 1'b0;
        tick(2);
        check("g5_idle_stop", bus.o_stop, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
